axi_sample_trigger: RTL

Consumes the divided clock produced by the clock-divider stage and turns it into single-cycle sample strobes in the main clk domain. It supports continuous and burst sampling, optional edge decimation, a running sample index, and busy/done status. It sits between the clock divider and the sample-generation datapath. Its control inputs come from the AXI register bank (EnableSampleGeneration and related registers).

---
 rtl/axi_sample_trigger.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axi_sample_trigger.sv
// Sample strobe generator: turns clk_div rising edges into one-cycle
// sample ticks with burst, decimation and index tracking.
module axi_sample_trigger #(
    parameter int IDX_WIDTH   = 16,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clk_div,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   start,
    input  logic [IDX_WIDTH-1:0]   burst_len,
    input  logic [DECIM_WIDTH-1:0] decim,
    output logic                   sample_tick,
    output logic [IDX_WIDTH-1:0]   sample_index,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic                   clk_div_q;
    logic                   rise;
    logic                   mode_q;
    logic [IDX_WIDTH-1:0]   blen_q;
    logic [DECIM_WIDTH-1:0] dlim_q;
    logic [DECIM_WIDTH-1:0] dlim;
    logic [DECIM_WIDTH-1:0] dcnt;
    logic [DECIM_WIDTH-1:0] dcnt_n;
    logic [IDX_WIDTH-1:0]   cnt;
    logic [IDX_WIDTH-1:0]   cnt_n;
    logic [IDX_WIDTH-1:0]   index_n;
    logic                   strobe;
    logic                   last;
    logic                   arm;
    logic                   tick_n;
    logic                   done_n;

    assign rise = clk_div & ~clk_div_q;

    // decim of 0 and 1 both mean every edge
    assign dlim = (decim == '0) ? '0 : decim - DECIM_WIDTH'(1);

    assign last = mode_q && (cnt == blen_q - IDX_WIDTH'(1));

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        cnt_n   = cnt;
        index_n = sample_index;
        strobe  = 1'b0;
        arm     = 1'b0;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !mode) begin
                    arm = 1'b1;
                end else if (enable && mode && start) begin
                    if (burst_len == '0) done_n = 1'b1;
                    else                 arm    = 1'b1;
                end
                if (arm) begin
                    state_n = ARMED;
                    cnt_n   = '0;
                    index_n = '0;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_n = DONE;
                end else if (rise) begin
                    strobe  = 1'b1;
                    state_n = RUN;
                    dcnt_n  = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n = DONE;
                end else if (rise) begin
                    if (dcnt == dlim_q) begin
                        strobe = 1'b1;
                        dcnt_n = '0;
                    end else begin
                        dcnt_n = dcnt + DECIM_WIDTH'(1);
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (strobe) begin
            tick_n  = 1'b1;
            index_n = cnt;
            cnt_n   = cnt + IDX_WIDTH'(1);
            if (last) state_n = DONE;
        end
        if (state_n == DONE) done_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            clk_div_q    <= 1'b0;
            dcnt         <= '0;
            cnt          <= '0;
            mode_q       <= 1'b0;
            blen_q       <= '0;
            dlim_q       <= '0;
            sample_tick  <= 1'b0;
            sample_index <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            clk_div_q    <= clk_div;
            dcnt         <= dcnt_n;
            cnt          <= cnt_n;
            sample_tick  <= tick_n;
            sample_index <= index_n;
            busy         <= (state_n == ARMED) ||
                            (state_n == RUN);
            done         <= done_n;
            if (arm) begin
                mode_q <= mode;
                blen_q <= burst_len;
                dlim_q <= dlim;
            end
        end
    end

endmodule
